jtopl_wr_sched: RTL and testbench

Host-write scheduler for the OPL register file. Captures CPU address/data port writes, decodes the OPL register map into group/subslot selects and per-field update strobes, and holds each slot-register update for one complete 18-slot sweep of the slot counter so that the targeted slot or channel is written. Global registers (0x01, 0xBD) are applied immediately. Sits between the CPU bus and `jtopl_reg`, and drives that block's `din`, `write`, `sel_*`, `up_*`, `rhy_*` and `wave_mode` inputs.

---
 rtl/jtopl_wr_sched_if.sv | 13 +
 rtl/jtopl_wr_sched.sv | 165 ++++++++++++++++
 tb/tb_jtopl_wr_sched.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtopl_wr_sched_if.sv
// Host CPU bus into the OPL write scheduler: port strobes and data in,
// busy / lost-write status back to the host.
interface jtopl_wr_sched_if;
    logic       cs_n;
    logic       wr_n;
    logic       addr;
    logic [7:0] din;
    logic       busy;
    logic       wr_lost;

    modport master (output cs_n, wr_n, addr, din, input  busy, wr_lost);
    modport slave  (input  cs_n, wr_n, addr, din, output busy, wr_lost);
endinterface

// File: rtl/jtopl_wr_sched.sv
// OPL host-write scheduler: decodes CPU register writes and holds each
// slot-register update for a full 18-slot sweep; globals apply at once.
module jtopl_wr_sched #(
    parameter int OPL_TYPE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic                   zero,
    jtopl_wr_sched_if.slave        host,
    output logic                   write,
    output logic [7:0]             dout,
    output logic [1:0]             sel_group,
    output logic [2:0]             sel_sub,
    output logic                   up_mult,
    output logic                   up_ksl_tl,
    output logic                   up_ar_dr,
    output logic                   up_sl_rr,
    output logic                   up_wav,
    output logic                   up_fnumlo,
    output logic                   up_fnumhi,
    output logic                   up_fbcon,
    output logic                   rhy_en,
    output logic [4:0]             rhy_kon,
    output logic                   am_dep,
    output logic                   vib_dep,
    output logic                   wave_mode
);
    localparam bit IS_OPL2 = (OPL_TYPE != 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_SWEEP} state_t;

    state_t     state_q;
    logic       last_q;
    logic [7:0] areg_q;
    logic       write_q;
    logic [7:0] dout_q;
    logic [1:0] grp_q;
    logic [2:0] sub_q;
    logic [7:0] up_q;
    logic       busy_q;
    logic       lost_q;
    logic [7:0] glb_q;
    logic       wave_q;

    logic [7:0] up_d;
    logic [1:0] grp_d;
    logic [2:0] sub_d;
    logic [4:0] op;
    logic [3:0] ch;
    logic       op_ok, ch_ok, is_bd, is_wave, wr_low, acc;

    assign wr_low  = ~host.cs_n & ~host.wr_n;
    assign acc     = wr_low & ~last_q;
    assign op      = areg_q[4:0];
    assign ch      = areg_q[3:0];
    assign op_ok   = (op[4:3] != 2'd3) && (op[2:0] < 3'd6);
    assign ch_ok   = (ch <= 4'd8);
    assign is_bd   = (areg_q == 8'hBD);
    assign is_wave = IS_OPL2 && (areg_q == 8'h01);

    always_comb begin
        up_d  = '0;
        grp_d = op[4:3];
        sub_d = op[2:0];
        case (areg_q[7:5])
            3'd1:    up_d[0] = op_ok;
            3'd2:    up_d[1] = op_ok;
            3'd3:    up_d[2] = op_ok;
            3'd4:    up_d[3] = op_ok;
            3'd7:    up_d[4] = op_ok && IS_OPL2;
            3'd5: begin
                up_d[5] = ~areg_q[4] & ch_ok;
                up_d[6] =  areg_q[4] & ch_ok;
            end
            3'd6:    up_d[7] = ~areg_q[4] & ch_ok;
            default: ;
        endcase
        // Channel regs: ch/3 and ch%3 for ch 0..8; the 3-bit subtract wraps 8-6 correctly.
        if (areg_q[7:5] == 3'd5 || areg_q[7:5] == 3'd6) begin
            if (ch < 4'd3) begin
                grp_d = 2'd0;
                sub_d = ch[2:0];
            end else if (ch < 4'd6) begin
                grp_d = 2'd1;
                sub_d = ch[2:0] - 3'd3;
            end else begin
                grp_d = 2'd2;
                sub_d = ch[2:0] - 3'd6;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b0;
            areg_q  <= '0;
            write_q <= 1'b0;
            dout_q  <= '0;
            grp_q   <= '0;
            sub_q   <= '0;
            up_q    <= '0;
            busy_q  <= 1'b0;
            lost_q  <= 1'b0;
            glb_q   <= '0;
            wave_q  <= 1'b0;
        end else begin
            last_q  <= wr_low;
            write_q <= 1'b0;
            if (acc) begin
                if (!host.addr) begin
                    areg_q <= host.din;
                    lost_q <= 1'b0;
                end else if (is_bd) begin
                    glb_q <= host.din;
                end else if (is_wave) begin
                    wave_q <= host.din[5];
                end else if (state_q != S_IDLE) begin
                    lost_q <= 1'b1;
                end else if (up_d != '0) begin
                    write_q <= 1'b1;
                    dout_q  <= host.din;
                    grp_q   <= grp_d;
                    sub_q   <= sub_d;
                    up_q    <= up_d;
                    busy_q  <= 1'b1;
                    state_q <= S_ARM;
                end
            end
            // A zero event in the acceptance clk sees S_IDLE, so it is never counted.
            if (cen && zero) begin
                case (state_q)
                    S_ARM:   state_q <= S_SWEEP;
                    S_SWEEP: begin
                        state_q <= S_IDLE;
                        up_q    <= '0;
                        busy_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign host.busy    = busy_q;
    assign host.wr_lost = lost_q;
    assign write        = write_q;
    assign dout         = dout_q;
    assign sel_group    = grp_q;
    assign sel_sub      = sub_q;
    assign up_mult      = up_q[0];
    assign up_ksl_tl    = up_q[1];
    assign up_ar_dr     = up_q[2];
    assign up_sl_rr     = up_q[3];
    assign up_wav       = up_q[4];
    assign up_fnumlo    = up_q[5];
    assign up_fnumhi    = up_q[6];
    assign up_fbcon     = up_q[7];
    assign am_dep       = glb_q[7];
    assign vib_dep      = glb_q[6];
    assign rhy_en       = glb_q[5];
    assign rhy_kon      = glb_q[4:0];
    assign wave_mode    = wave_q;
endmodule

// File: tb/tb_jtopl_wr_sched.sv
// Bench for jtopl_wr_sched: an OPL and an OPL2 instance share one host bus and
// are checked every clk against a register-map / zero-event counting model.
module tb_jtopl_wr_sched;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen   = 1'b0;
    logic       zero  = 1'b0;
    logic       cs_n  = 1'b1;
    logic       wr_n  = 1'b1;
    logic       addr  = 1'b0;
    logic [7:0] din   = '0;

    always #5 clk = ~clk;

    jtopl_wr_sched_if bus0 ();
    jtopl_wr_sched_if bus1 ();
    assign bus0.cs_n = cs_n;
    assign bus0.wr_n = wr_n;
    assign bus0.addr = addr;
    assign bus0.din  = din;
    assign bus1.cs_n = cs_n;
    assign bus1.wr_n = wr_n;
    assign bus1.addr = addr;
    assign bus1.din  = din;

    logic [1:0]      w_o, wave_o, busy_o, lost_o;
    logic [1:0][7:0] dout_o, up_o, glb_o;
    logic [1:0][1:0] grp_o;
    logic [1:0][2:0] sub_o;
    assign busy_o = {bus1.busy, bus0.busy};
    assign lost_o = {bus1.wr_lost, bus0.wr_lost};

    jtopl_wr_sched #(.OPL_TYPE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .host(bus0),
        .write(w_o[0]), .dout(dout_o[0]), .sel_group(grp_o[0]), .sel_sub(sub_o[0]),
        .up_mult(up_o[0][0]), .up_ksl_tl(up_o[0][1]), .up_ar_dr(up_o[0][2]), .up_sl_rr(up_o[0][3]),
        .up_wav(up_o[0][4]), .up_fnumlo(up_o[0][5]), .up_fnumhi(up_o[0][6]), .up_fbcon(up_o[0][7]),
        .rhy_en(glb_o[0][5]), .rhy_kon(glb_o[0][4:0]), .am_dep(glb_o[0][7]), .vib_dep(glb_o[0][6]),
        .wave_mode(wave_o[0])
    );

    jtopl_wr_sched #(.OPL_TYPE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero), .host(bus1),
        .write(w_o[1]), .dout(dout_o[1]), .sel_group(grp_o[1]), .sel_sub(sub_o[1]),
        .up_mult(up_o[1][0]), .up_ksl_tl(up_o[1][1]), .up_ar_dr(up_o[1][2]), .up_sl_rr(up_o[1][3]),
        .up_wav(up_o[1][4]), .up_fnumlo(up_o[1][5]), .up_fnumhi(up_o[1][6]), .up_fbcon(up_o[1][7]),
        .rhy_en(glb_o[1][5]), .rhy_kon(glb_o[1][4:0]), .am_dep(glb_o[1][7]), .vib_dep(glb_o[1][6]),
        .wave_mode(wave_o[1])
    );

    // Reference model, index 0 = OPL, 1 = OPL2
    int m_areg[2], m_zc[2];
    bit m_last[2], m_pend[2];
    int e_write[2], e_dout[2], e_grp[2], e_sub[2], e_up[2];
    int e_busy[2], e_lost[2], e_glb[2], e_wave[2];
    int n_tests = 0;
    int n_fail  = 0;
    int slot    = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] up;
        logic [7:0] up2;
        int         g;
        int         s;
        logic [7:0] glb;
        logic       wv2;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_areg[k] = 0; m_zc[k] = 0; m_last[k] = 0; m_pend[k] = 0;
            e_write[k] = 0; e_dout[k] = 0; e_grp[k] = 0; e_sub[k] = 0; e_up[k] = 0;
            e_busy[k] = 0; e_lost[k] = 0; e_glb[k] = 0; e_wave[k] = 0;
        end
    endfunction

    function automatic void decode(input int a, input bit opl2, output int up, output int g, output int s);
        int ob[5];
        int cb[3];
        ob = '{'h20, 'h40, 'h60, 'h80, 'hE0};
        cb = '{'hA0, 'hB0, 'hC0};
        up = 0; g = 0; s = 0;
        for (int i = 0; i < 5; i++)
            if (a >= ob[i] && a <= ob[i] + 'h15 && ((a - ob[i]) % 8) < 6 && (i < 4 || opl2)) begin
                up = 1 << i; g = (a - ob[i]) / 8; s = (a - ob[i]) % 8;
            end
        for (int i = 0; i < 3; i++)
            if (a >= cb[i] && a <= cb[i] + 8) begin
                up = 1 << (5 + i); g = (a - cb[i]) / 3; s = (a - cb[i]) % 3;
            end
    endfunction

    function automatic void model_step(input bit c, input bit w, input bit a, input int d,
                                       input bit ce, input bit z);
        for (int k = 0; k < 2; k++) begin
            bit low, acc, was;
            int up, g, s;
            low = !c && !w;
            acc = low && !m_last[k];
            m_last[k] = low;
            was = m_pend[k];
            e_write[k] = 0;
            if (acc) begin
                if (!a) begin
                    m_areg[k] = d; e_lost[k] = 0;
                end else if (m_areg[k] == 'hBD) begin
                    e_glb[k] = d;
                end else if (m_areg[k] == 'h01 && k == 1) begin
                    e_wave[k] = (d >> 5) & 1;
                end else begin
                    decode(m_areg[k], k == 1, up, g, s);
                    if (was) e_lost[k] = 1;
                    else if (up != 0) begin
                        e_write[k] = 1; e_dout[k] = d; e_grp[k] = g; e_sub[k] = s; e_up[k] = up;
                        e_busy[k] = 1; m_pend[k] = 1; m_zc[k] = 0;
                    end
                end
            end
            if (was && ce && z) begin
                m_zc[k]++;
                if (m_zc[k] == 2) begin
                    m_pend[k] = 0; e_busy[k] = 0; e_up[k] = 0;
                end
            end
        end
    endfunction

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("write[%0d]", k),     w_o[k],    e_write[k]);
            chk($sformatf("dout[%0d]", k),      dout_o[k], e_dout[k]);
            chk($sformatf("sel_group[%0d]", k), grp_o[k],  e_grp[k]);
            chk($sformatf("sel_sub[%0d]", k),   sub_o[k],  e_sub[k]);
            chk($sformatf("up[%0d]", k),        up_o[k],   e_up[k]);
            chk($sformatf("busy[%0d]", k),      busy_o[k], e_busy[k]);
            chk($sformatf("wr_lost[%0d]", k),   lost_o[k], e_lost[k]);
            chk($sformatf("bd_regs[%0d]", k),   glb_o[k],  e_glb[k]);
            chk($sformatf("wave_mode[%0d]", k), wave_o[k], e_wave[k]);
        end
    endtask

    task automatic cycle_cz(input bit c, input bit w, input bit a, input int d,
                            input bit ce, input bit z);
        cs_n = c; wr_n = w; addr = a; din = d[7:0]; cen = ce; zero = z;
        model_step(c, w, a, d, ce, z);
        @(negedge clk);
        check_all();
    endtask

    task automatic cycle(input bit c, input bit w, input bit a, input int d);
        bit ce, z;
        ce = ($urandom_range(0, 3) != 0);
        z  = (slot == 0);
        if (ce) slot = (slot == 17) ? 0 : slot + 1;
        cycle_cz(c, w, a, d, ce, z);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o != 2'b00 && n < 300) begin
            cycle(1, 1, 0, 0);
            n++;
        end
        chk("release_timeout", busy_o, 0);
    endtask

    initial begin
        int pulses, n, c, w, a, d;
        int pool[20];
        pool = '{'h20, 'h48, 'h35, 'h36, 'h3D, 'hB7, 'hA9, 'hA8, 'hC8, 'hC9,
                 'hBD, 'h01, 'hF5, 'hE3, 'h95, 'h75, 'h00, 'hFF, 'h26, 'h60};

        //          addr   data   up     up2    g  s  glb    wv2
        tbl.push_back('{8'h48, 8'h3F, 8'h02, 8'h02, 1, 0, 8'h00, 1'b0});
        tbl.push_back('{8'hB7, 8'h2A, 8'h40, 8'h40, 2, 1, 8'h00, 1'b0});
        tbl.push_back('{8'hA9, 8'h11, 8'h00, 8'h00, 0, 0, 8'h00, 1'b0});
        tbl.push_back('{8'h26, 8'h55, 8'h00, 8'h00, 0, 0, 8'h00, 1'b0});
        tbl.push_back('{8'h20, 8'h01, 8'h01, 8'h01, 0, 0, 8'h00, 1'b0});
        tbl.push_back('{8'h35, 8'h02, 8'h01, 8'h01, 2, 5, 8'h00, 1'b0});
        tbl.push_back('{8'h3D, 8'h03, 8'h00, 8'h00, 0, 0, 8'h00, 1'b0});
        tbl.push_back('{8'h95, 8'h77, 8'h08, 8'h08, 2, 5, 8'h00, 1'b0});
        tbl.push_back('{8'hC8, 8'h0F, 8'h80, 8'h80, 2, 2, 8'h00, 1'b0});
        tbl.push_back('{8'hA0, 8'h33, 8'h20, 8'h20, 0, 0, 8'h00, 1'b0});
        tbl.push_back('{8'h75, 8'h44, 8'h04, 8'h04, 2, 5, 8'h00, 1'b0});
        tbl.push_back('{8'hF5, 8'h66, 8'h00, 8'h10, 2, 5, 8'h00, 1'b0});
        tbl.push_back('{8'hBD, 8'hF3, 8'h00, 8'h00, 0, 0, 8'hF3, 1'b0});
        tbl.push_back('{8'h01, 8'h20, 8'h00, 8'h00, 0, 0, 8'hF3, 1'b1});
        tbl.push_back('{8'hB3, 8'h19, 8'h40, 8'h40, 1, 0, 8'hF3, 1'b1});

        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        repeat (2) cycle(1, 1, 0, 0);

        foreach (tbl[i]) begin
            cycle(0, 0, 0, tbl[i].a);
            cycle(1, 1, 0, 0);
            cycle(0, 0, 1, tbl[i].d);
            chk("tbl_up1",    up_o[0],   tbl[i].up);
            chk("tbl_up2",    up_o[1],   tbl[i].up2);
            chk("tbl_busy1",  busy_o[0], tbl[i].up != 0);
            chk("tbl_busy2",  busy_o[1], tbl[i].up2 != 0);
            chk("tbl_write1", w_o[0],    tbl[i].up != 0);
            chk("tbl_bd",     glb_o[0],  tbl[i].glb);
            chk("tbl_wave1",  wave_o[0], 0);
            chk("tbl_wave2",  wave_o[1], tbl[i].wv2);
            if (tbl[i].up2 != 0) begin
                chk("tbl_dout", dout_o[1], tbl[i].d);
                chk("tbl_grp",  grp_o[1],  tbl[i].g);
                chk("tbl_sub",  sub_o[1],  tbl[i].s);
            end
            cycle(1, 1, 0, 0);
            chk("tbl_write_1clk", w_o, 0);
            wait_idle();
        end

        // Zero at acceptance ignored; hold through Z2; write at Z2 dropped
        cycle_cz(0, 0, 0, 'h48, 0, 0);
        cycle_cz(1, 1, 0, 0, 0, 0);
        cycle_cz(0, 0, 1, 'h3F, 1, 1);
        chk("acc_up", up_o[0], 'h02);
        repeat (4) cycle_cz(1, 1, 0, 0, 1, 0);
        cycle_cz(1, 1, 0, 0, 1, 1);
        chk("hold_after_z1", busy_o[0], 1);
        repeat (3) cycle_cz(1, 1, 0, 0, 1, 0);
        cycle_cz(1, 1, 0, 0, 0, 1);
        chk("hold_zero_no_cen", up_o[0], 'h02);
        cycle_cz(0, 0, 1, 'h99, 1, 1);
        chk("release_busy", busy_o[0], 0);
        chk("release_up",   up_o[0], 0);
        chk("drop_at_z2",   lost_o[0], 1);
        chk("shadow_kept",  dout_o[0], 'h3F);
        cycle_cz(1, 1, 0, 0, 0, 0);
        cycle_cz(0, 0, 0, 'h20, 0, 0);
        chk("lost_clear", lost_o[0], 0);
        cycle_cz(1, 1, 0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle_cz(0, 0, 1, 'h5A, 0, 0);
            pulses += int'(w_o[0]);
        end
        chk("one_accept", pulses, 1);
        chk("held_dout", dout_o[0], 'h5A);
        cycle_cz(1, 1, 0, 0, 1, 1);
        cycle_cz(1, 1, 0, 0, 1, 1);
        chk("b2b_released", busy_o[0], 0);
        cycle_cz(0, 0, 1, 'h6B, 0, 0);
        chk("b2b_accept", w_o[0], 1);
        chk("b2b_dout", dout_o[0], 'h6B);
        cycle(1, 1, 0, 0);
        wait_idle();

        // Reset in the middle of a sweep
        cycle(0, 0, 0, 'h95);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 1, 'h11);
        n = 0;
        while (m_zc[0] < 1 && n < 200) begin
            cycle(1, 1, 0, 0);
            n++;
        end
        chk("reach_sweep", busy_o, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_up",   up_o, 0);
        chk("rst_dout", dout_o, 0);
        chk("rst_sel",  {grp_o, sub_o}, 0);
        chk("rst_glb",  {glb_o, wave_o, lost_o, w_o}, 0);
        model_reset();
        slot = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 'h20);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 1, 'h77);
        chk("post_rst_up",   up_o[0], 'h01);
        chk("post_rst_dout", dout_o[0], 'h77);
        wait_idle();

        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 2) == 0) ? 0 : 1;
            w = ($urandom_range(0, 1) == 0) ? 0 : 1;
            a = ($urandom_range(0, 4) < 2) ? 0 : 1;
            d = a ? int'($urandom_range(0, 255)) : pool[$urandom_range(0, 19)];
            cycle(c[0], w[0], a[0], d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
